pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_if.sv | 36 +++
 rtl/pipeline_hazard_controller.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Decode-side bundle between the decode stage and the hazard controller.
// master = decode/fetch side, slave = hazard controller.
interface pipeline_hazard_controller_if;
  logic        valid_IN;
  logic [2:0]  srcA_IN;
  logic [2:0]  srcB_IN;
  logic        srcA_use_IN;
  logic        srcB_use_IN;
  logic [2:0]  writeAd_IN;
  logic        write_IN;
  logic        ADR_MUX_IN;
  logic        PC_load_IN;

  logic [2:0]  writeAd_OUT;
  logic        write_OUT;
  logic        ADR_MUX_OUT;
  logic        PC_load_OUT;
  logic        stall_OUT;
  logic        issue_OUT;
  logic        flush_OUT;
  logic [15:0] stall_cnt_OUT;

  modport master (
    output valid_IN, srcA_IN, srcB_IN, srcA_use_IN, srcB_use_IN,
    output writeAd_IN, write_IN, ADR_MUX_IN, PC_load_IN,
    input  writeAd_OUT, write_OUT, ADR_MUX_OUT, PC_load_OUT,
    input  stall_OUT, issue_OUT, flush_OUT, stall_cnt_OUT
  );

  modport slave (
    input  valid_IN, srcA_IN, srcB_IN, srcA_use_IN, srcB_use_IN,
    input  writeAd_IN, write_IN, ADR_MUX_IN, PC_load_IN,
    output writeAd_OUT, write_OUT, ADR_MUX_OUT, PC_load_OUT,
    output stall_OUT, issue_OUT, flush_OUT, stall_cnt_OUT
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Decode hazard controller: write scoreboard stalls RAW reads, PC loads kill FLUSH_CYCLES fetches; control to next stage after 1 cycle, stall holds decode.
// Define HAZARD_BYPASS_EN to compare only scoreboard entry 0 (older results assumed forwarded).
module pipeline_hazard_controller #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  pipeline_hazard_controller_if.slave  hz
);

`ifdef HAZARD_BYPASS_EN
  localparam int MATCH_N = 1;
`else
  localparam int MATCH_N = DEPTH;
`endif
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state;
  logic [3:0]  flush_cnt;
  logic        flush_q;
  logic [DEPTH-1:0] sb_vld;
  logic [2:0]  sb_addr [DEPTH];

  logic        hit_a;
  logic        hit_b;
  logic        hazard;
  logic        stall;
  logic        issue;

  logic [2:0]  wa_q;
  logic        w_q;
  logic        am_q;
  logic        pl_q;
  logic [15:0] stall_cnt;

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < MATCH_N) && sb_vld[k]) begin
        if (sb_addr[k] == hz.srcA_IN) hit_a = 1'b1;
        if (sb_addr[k] == hz.srcB_IN) hit_b = 1'b1;
      end
    end
    // r0 is hard-wired zero, so reads of it never wait on a writer
    hazard = hz.valid_IN &
             ((hz.srcA_use_IN & (hz.srcA_IN != 3'd0) & hit_a) |
              (hz.srcB_use_IN & (hz.srcB_IN != 3'd0) & hit_b));
    stall  = hazard | (state == FLUSH);
    issue  = hz.valid_IN & ~stall;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
      flush_q   <= 1'b0;
      sb_vld    <= '0;
      for (int k = 0; k < DEPTH; k++) sb_addr[k] <= 3'd0;
      wa_q      <= 3'd0;
      w_q       <= 1'b0;
      am_q      <= 1'b0;
      pl_q      <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (issue && hz.PC_load_IN) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
            flush_q   <= 1'b1;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt <= 4'd1) begin
            state   <= RUN;
            flush_q <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          flush_q <= 1'b0;
        end
      endcase

      // The chain advances even while stalled, so a RAW stall lasts at most DEPTH cycles
      for (int k = 1; k < DEPTH; k++) begin
        sb_vld[k]  <= sb_vld[k-1];
        sb_addr[k] <= sb_addr[k-1];
      end
      if (issue && hz.write_IN && (hz.writeAd_IN != 3'd0)) begin
        sb_vld[0]  <= 1'b1;
        sb_addr[0] <= hz.writeAd_IN;
      end else begin
        sb_vld[0]  <= 1'b0;
        sb_addr[0] <= 3'd0;
      end

      if (issue) begin
        wa_q <= hz.writeAd_IN;
        w_q  <= hz.write_IN;
        am_q <= hz.ADR_MUX_IN;
        pl_q <= hz.PC_load_IN;
      end else begin
        wa_q <= 3'd0;
        w_q  <= 1'b0;
        am_q <= 1'b0;
        pl_q <= 1'b0;
      end

      if (hz.valid_IN && stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign hz.stall_OUT     = stall;
  assign hz.issue_OUT     = issue;
  assign hz.flush_OUT     = flush_q;
  assign hz.writeAd_OUT   = wa_q;
  assign hz.write_OUT     = w_q;
  assign hz.ADR_MUX_OUT   = am_q;
  assign hz.PC_load_OUT   = pl_q;
  assign hz.stall_cnt_OUT = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: per-register ready-time model, registered outputs via expectation queue.
module tb_pipeline_hazard_controller;
  localparam int DEPTH = 3;
  localparam int FLUSH = 2;
`ifdef HAZARD_BYPASS_EN
  localparam int MATCH_N     = 1;
  localparam int EXP_R27_CNT = 1;
`else
  localparam int MATCH_N     = DEPTH;
  localparam int EXP_R27_CNT = 3;
`endif

  logic CLK = 1'b0;
  logic RST_N;

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .hz    (hz)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  wa;
    logic        w;
    logic        am;
    logic        pl;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ready[8];
  int   flush_last = -1;
  int   exp_cnt  = 0;
  bit   known    = 1'b0;
  logic obs_stall, obs_issue, obs_flush, obs_pl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive, check mid-cycle, advance the model, wait for the next edge.
  task automatic cycle(input bit rst, input bit v, input logic [2:0] a, input logic [2:0] b,
                       input bit au, input bit bu, input logic [2:0] wa, input bit w,
                       input bit am, input bit pl);
    bit   haz, fl, st, is;
    exp_t e;
    RST_N          = rst;
    hz.valid_IN    = v;
    hz.srcA_IN     = a;
    hz.srcB_IN     = b;
    hz.srcA_use_IN = au;
    hz.srcB_use_IN = bu;
    hz.writeAd_IN  = wa;
    hz.write_IN    = w;
    hz.ADR_MUX_IN  = am;
    hz.PC_load_IN  = pl;
    #2;
    fl  = (cyc <= flush_last);
    haz = v && ((au && a != 3'd0 && cyc < ready[a]) || (bu && b != 3'd0 && cyc < ready[b]));
    st  = haz || fl;
    is  = v && !st;
    obs_stall = hz.stall_OUT;
    obs_issue = hz.issue_OUT;
    obs_flush = hz.flush_OUT;
    obs_pl    = hz.PC_load_OUT;
    if (known) begin
      chk("stall", 32'(hz.stall_OUT), 32'(st));
      chk("issue", 32'(hz.issue_OUT), 32'(is));
      chk("flush", 32'(hz.flush_OUT), 32'(fl));
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("writeAd", 32'(hz.writeAd_OUT), 32'(e.wa));
      chk("write", 32'(hz.write_OUT), 32'(e.w));
      chk("adr_mux", 32'(hz.ADR_MUX_OUT), 32'(e.am));
      chk("pc_load", 32'(hz.PC_load_OUT), 32'(e.pl));
      chk("stall_cnt", 32'(hz.stall_cnt_OUT), 32'(e.cnt));
    end
    if (!rst) begin
      for (int i = 0; i < 8; i++) ready[i] = 0;
      flush_last = -1;
      exp_cnt    = 0;
      e = '{3'd0, 1'b0, 1'b0, 1'b0, 16'd0};
      known = 1'b1;
    end else begin
      if (is && w && wa != 3'd0) ready[wa] = cyc + 1 + MATCH_N;
      if (is && pl) flush_last = cyc + FLUSH;
      if (v && st && exp_cnt < 65535) exp_cnt++;
      e.wa  = is ? wa : 3'd0;
      e.w   = is ? w : 1'b0;
      e.am  = is ? am : 1'b0;
      e.pl  = is ? pl : 1'b0;
      e.cnt = 16'(exp_cnt);
    end
    exp_q.push_back(e);
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input bit rst);
    cycle(rst, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ready[i] = 0;
    RST_N          = 1'b0;
    hz.valid_IN    = 1'b0;
    hz.srcA_IN     = 3'd0;
    hz.srcB_IN     = 3'd0;
    hz.srcA_use_IN = 1'b0;
    hz.srcB_use_IN = 1'b0;
    hz.writeAd_IN  = 3'd0;
    hz.write_IN    = 1'b0;
    hz.ADR_MUX_IN  = 1'b0;
    hz.PC_load_IN  = 1'b0;
    @(posedge CLK);
    #1;

    // Reset held two cycles under random inputs
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_writeAd", 32'(hz.writeAd_OUT), 32'd0);
    chk("rst_write", 32'(hz.write_OUT), 32'd0);
    chk("rst_pc_load", 32'(hz.PC_load_OUT), 32'd0);
    chk("rst_flush", 32'(hz.flush_OUT), 32'd0);
    chk("rst_cnt", 32'(hz.stall_cnt_OUT), 32'd0);

    // RAW on r3: stall length set by scoreboard depth
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("r27_issue_t4", 32'(obs_issue), 32'd1);
    idle(1'b1);
    chk("r27_cnt", 32'(hz.stall_cnt_OUT), 32'(EXP_R27_CNT));

    // Write to r0 never blocks a read of r0
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("r28_issue", 32'(obs_issue), 32'd1);
    chk("r28_stall", 32'(obs_stall), 32'd0);

    // PC load: two killed fetch cycles
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("r29_pl_t1", 32'(obs_pl), 32'd1);
    chk("r29_flush_t1", 32'(obs_flush), 32'd1);
    chk("r29_issue_t1", 32'(obs_issue), 32'd0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("r29_flush_t2", 32'(obs_flush), 32'd1);
    chk("r29_issue_t2", 32'(obs_issue), 32'd0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("r29_flush_t3", 32'(obs_flush), 32'd0);
    chk("r29_issue_t3", 32'(obs_issue), 32'd1);

    // Reset during the first flush cycle clears flush and scoreboard
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("r30_flush_during_rst", 32'(obs_flush), 32'd1);
    cycle(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("r30_flush", 32'(obs_flush), 32'd0);
    chk("r30_stall", 32'(obs_stall), 32'd0);
    chk("r30_issue", 32'(obs_issue), 32'd1);

    // Hazard with PC load: nothing issues, no flush
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("r31_issue", 32'(obs_issue), 32'd0);
    chk("r31_flush", 32'(obs_flush), 32'd0);
    idle(1'b1);
    chk("r31_pl_next", 32'(obs_pl), 32'd0);
    chk("r31_flush_next", 32'(obs_flush), 32'd0);

    // Random traffic on a small register set with occasional resets
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), ($urandom_range(0, 11) == 0));
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
